rr_arbiter8: RTL and testbench

//   Round-robin arbiter sharing one resource among 8 requesters. Search order starts after the last winner.

---
 rtl/rr_arbiter8.sv | 131 +++++++++++++
 tb/tb_rr_arbiter8.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant held until the owner drops req.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  if (HOLD_MAX == 0 || HOLD_MAX > (1 << CNT_W)) begin : gen_param_check
    $error("rr_arbiter8: HOLD_MAX must lie in 1..2**CNT_W");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] win;
  logic       found;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;
`endif

  // Rotating priority: first set request at or after ptr wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int i = 0; i < 8; i++) begin
      if (!found && req[ptr_q + 3'(i)]) begin
        found = 1'b1;
        win   = ptr_q + 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        gnt_d = 8'h00;
        if (en && found) begin
          gnt_d   = 8'h01 << win;
          idx_d   = win;
          state_d = StGrant;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      StGrant: begin
        if (!req[idx_q]) begin
          gnt_d   = 8'h00;
          ptr_d   = idx_q + 3'd1;
          state_d = StGap;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_q == HoldLast) begin
          gnt_d     = 8'h00;
          ptr_d     = idx_q + 3'd1;
          preempt_d = 1'b1;
          state_d   = StGap;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
`endif
        end
      end
      StGap: begin
        gnt_d   = 8'h00;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 8'h00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      gnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: cycle table plus reset and hold/timeout sequences.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int total;
  int bad;

  rr_arbiter8 #(
    .HOLD_MAX(4),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic [7:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [7:0] g, input logic [2:0] i,
                         input logic v, input logic p);
    chk({name, ".gnt"}, gnt, g);
    chk({name, ".idx"}, {5'd0, gnt_idx}, {5'd0, i});
    chk({name, ".valid"}, {7'd0, gnt_valid}, {7'd0, v});
    chk({name, ".preempt"}, {7'd0, preempt}, {7'd0, p});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    en    = 1'b0;
    req   = 8'h00;
    rst_n = 1'b0;

    //        en    req    gnt    idx   valid
    vecs[0]  = '{1'b1, 8'h24, 8'h04, 3'd2, 1'b1};
    vecs[1]  = '{1'b1, 8'h20, 8'h00, 3'd2, 1'b0};
    vecs[2]  = '{1'b1, 8'h20, 8'h00, 3'd2, 1'b0};
    vecs[3]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
    vecs[4]  = '{1'b1, 8'h03, 8'h00, 3'd5, 1'b0};
    vecs[5]  = '{1'b1, 8'h03, 8'h00, 3'd5, 1'b0};
    vecs[6]  = '{1'b1, 8'h03, 8'h01, 3'd0, 1'b1};
    vecs[7]  = '{1'b1, 8'h02, 8'h00, 3'd0, 1'b0};
    vecs[8]  = '{1'b1, 8'h02, 8'h00, 3'd0, 1'b0};
    vecs[9]  = '{1'b1, 8'h02, 8'h02, 3'd1, 1'b1};
    vecs[10] = '{1'b1, 8'h00, 8'h00, 3'd1, 1'b0};
    vecs[11] = '{1'b0, 8'hFF, 8'h00, 3'd1, 1'b0};
    vecs[12] = '{1'b0, 8'hFF, 8'h00, 3'd1, 1'b0};
    vecs[13] = '{1'b1, 8'hFF, 8'h04, 3'd2, 1'b1};
    vecs[14] = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1};
    vecs[15] = '{1'b0, 8'hFF, 8'h04, 3'd2, 1'b1};
    vecs[16] = '{1'b0, 8'hFB, 8'h00, 3'd2, 1'b0};
    vecs[17] = '{1'b0, 8'hFB, 8'h00, 3'd2, 1'b0};
    vecs[18] = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1};
    vecs[19] = '{1'b1, 8'h81, 8'h80, 3'd7, 1'b1};
    vecs[20] = '{1'b1, 8'h01, 8'h00, 3'd7, 1'b0};
    vecs[21] = '{1'b1, 8'h81, 8'h00, 3'd7, 1'b0};
    vecs[22] = '{1'b1, 8'h81, 8'h01, 3'd0, 1'b1};
    vecs[23] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};

    #12;
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 24; k++) begin
      step(vecs[k].en, vecs[k].req);
      chk_out($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].idx, vecs[k].valid, 1'b0);
    end

    // Asynchronous reset in the middle of a grant, between clock edges.
    step(1'b1, 8'h10);
    step(1'b1, 8'h10);
    step(1'b1, 8'h10);
    chk_out("pre_rst", 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // ptr back to 0 after reset: lowest requester wins.
    step(1'b1, 8'h41);
    chk_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ARB_TIMEOUT_EN
    // HOLD_MAX=4: two persistent requesters alternate via timeout.
    step(1'b1, 8'h48);
    chk_out("to_g3_0", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int c = 1; c < 4; c++) begin
      step(1'b1, 8'h48);
      chk_out($sformatf("to_g3_%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    step(1'b1, 8'h48);
    chk_out("to_pre3", 8'h00, 3'd3, 1'b0, 1'b1);
    step(1'b1, 8'h48);
    chk_out("to_idle3", 8'h00, 3'd3, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 8'h48);
      chk_out($sformatf("to_g6_%0d", c), 8'h40, 3'd6, 1'b1, 1'b0);
    end
    step(1'b1, 8'h48);
    chk_out("to_pre6", 8'h00, 3'd6, 1'b0, 1'b1);
    step(1'b1, 8'h48);
    chk_out("to_idle6", 8'h00, 3'd6, 1'b0, 1'b0);
    step(1'b1, 8'h48);
    chk_out("to_g3_again", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int c = 1; c < 4; c++) step(1'b1, 8'h48);
    // Voluntary release on the timeout edge is a normal release.
    step(1'b1, 8'h40);
    chk_out("to_same_edge", 8'h00, 3'd3, 1'b0, 1'b0);
`else
    step(1'b1, 8'h08);
    chk_out("hold_start", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int c = 0; c < 100; c++) begin
      step(1'b1, 8'h48);
      chk_out($sformatf("hold%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    step(1'b1, 8'h40);
    chk_out("hold_release", 8'h00, 3'd3, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
